// File: rtl/sdm2_echip65_pkg.sv
// Shared constants for the sdm2_echip65 second-order sigma-delta modulator.
// Optional dither (macro SDM2_DITHER_EN) uses the LFSR constants defined here.
package sdm2_echip65_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_PRIME = 2'd1;
  localparam state_t ST_RUN   = 2'd2;

  // x^15 + x^14 + 1, Fibonacci form: feedback taps are bits 14 and 13.
  localparam int         LFSR_WIDTH = 15;
  localparam logic [14:0] LFSR_POLY = 15'h6000;
  localparam logic [14:0] LFSR_SEED = 15'h0001;

  function automatic logic signed [63:0] full_scale(input int width);
    return 64'sd1 <<< (width - 1);
  endfunction

endpackage

// File: rtl/sdm2_echip65_loop.sv
// Two-integrator sigma-delta loop with saturation, sticky overload and 1-bit quantizer.
// Define SDM2_DITHER_EN to add a +/-1 LSB LFSR dither at the quantizer input.
module sdm2_echip65_loop
  import sdm2_echip65_pkg::*;
#(
  parameter int IN_WIDTH  = 16,
  parameter int ACC_WIDTH = 20
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                run_i,
  input  logic                idle_i,
  input  logic [IN_WIDTH-1:0] x_i,
  output logic                out_o,
  output logic                overload_o
);

  // Two guard bits keep every intermediate sum exact before saturation.
  localparam int W = ACC_WIDTH + 2;
  localparam logic signed [W-1:0] FS      = W'(full_scale(IN_WIDTH));
  localparam logic signed [W-1:0] SAT_MAX = W'(full_scale(ACC_WIDTH) - 64'sd1);
  localparam logic signed [W-1:0] SAT_MIN = W'(-full_scale(ACC_WIDTH));

  function automatic logic signed [W-1:0] saturate(input logic signed [W-1:0] v);
    if (v > SAT_MAX) return SAT_MAX;
    if (v < SAT_MIN) return SAT_MIN;
    return v;
  endfunction

  logic signed [ACC_WIDTH-1:0] int1_q, int1_d, int2_q, int2_d;
  logic                        out_q, out_d, ovl_q, ovl_d;
  logic signed [W-1:0]         x_ext, fb, sum1, sum2, int1_w, int2_w, quant, dither;

`ifdef SDM2_DITHER_EN
  localparam logic signed [W-1:0] ONE = W'(1);
  logic [LFSR_WIDTH-1:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (run_i) lfsr_d = {lfsr_q[LFSR_WIDTH-2:0], ^(lfsr_q & LFSR_POLY)};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) lfsr_q <= LFSR_SEED;
    else          lfsr_q <= lfsr_d;
  end

  assign dither = lfsr_q[0] ? ONE : -ONE;
`else
  assign dither = '0;
`endif

  // NOTE: every always_comb output is given a default first so no latch is inferred.
  always_comb begin
    x_ext  = W'($signed(x_i));
    fb     = out_q ? FS : -FS;
    sum1   = W'(int1_q) + x_ext - fb;
    int1_w = saturate(sum1);
    sum2   = W'(int2_q) + int1_w - fb;
    int2_w = saturate(sum2);
    quant  = int2_w + dither;

    int1_d = '0;
    int2_d = '0;
    out_d  = ~out_q;
    ovl_d  = ovl_q && !idle_i;
    if (run_i) begin
      int1_d = int1_w[ACC_WIDTH-1:0];
      int2_d = int2_w[ACC_WIDTH-1:0];
      out_d  = ~quant[W-1];
      if ((sum1 != int1_w) || (sum2 != int2_w)) ovl_d = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      int1_q <= '0;
      int2_q <= '0;
      out_q  <= 1'b0;
      ovl_q  <= 1'b0;
    end else begin
      int1_q <= int1_d;
      int2_q <= int2_d;
      out_q  <= out_d;
      ovl_q  <= ovl_d;
    end
  end

  assign out_o      = out_q;
  assign overload_o = ovl_q;

endmodule

// File: rtl/sdm2_echip65.sv
// sdm2_echip65 top: run FSM, decimation counter, one-entry sample holding register.
// Optional quantizer dither is enabled by defining SDM2_DITHER_EN.
module sdm2_echip65
  import sdm2_echip65_pkg::*;
#(
  parameter int DECIMATION_FACTOR = 256,
  parameter int IN_WIDTH          = 16,
  parameter int ACC_WIDTH         = IN_WIDTH + 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic [IN_WIDTH-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                out,
  output logic                divided_clk,
  output logic                underrun,
  output logic                overload
);

  localparam int              CNT_W    = $clog2(DECIMATION_FACTOR);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIMATION_FACTOR - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IN_WIDTH-1:0] hold_q, hold_d, active_q, active_d;
  logic                hold_full_q, hold_full_d;
  logic                div_q, div_d, underrun_q, underrun_d;
  logic                boundary, accept, take, run, idle;

  assign boundary = (state_q != ST_IDLE) && (cnt_q == CNT_LAST);
  assign accept   = in_valid && !hold_full_q;
  assign take     = boundary && hold_full_q;
  assign run      = (state_q == ST_RUN);
  assign idle     = (state_q == ST_IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (enable) state_d = ST_PRIME;
      ST_PRIME: if (take)   state_d = ST_RUN;
      ST_RUN:   state_d = ST_RUN;
      default:  state_d = ST_IDLE;
    endcase
    if (!enable) state_d = ST_IDLE;

    // Counter restarts from zero on every IDLE exit and is held in IDLE.
    cnt_d = ((state_q != ST_IDLE) && (state_d != ST_IDLE)) ? cnt_q + 1'b1 : '0;

    // A handshake can only land in an empty register, so it never races the boundary move.
    hold_d      = accept ? in_data : hold_q;
    hold_full_d = accept ? 1'b1 : (take ? 1'b0 : hold_full_q);
    active_d    = take ? hold_q : active_q;
    underrun_d  = boundary && run && !hold_full_q;
    div_d       = cnt_q[CNT_W-1];
  end

  // NOTE: the sample registers are reset too, so a reset mid-run discards stale data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      active_q    <= '0;
      div_q       <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      active_q    <= active_d;
      div_q       <= div_d;
      underrun_q  <= underrun_d;
    end
  end

  assign in_ready    = ~hold_full_q;
  assign divided_clk = div_q;
  assign underrun    = underrun_q;

  sdm2_echip65_loop #(
    .IN_WIDTH  (IN_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_loop (
    .clk        (clk),
    .reset_n    (reset_n),
    .run_i      (run),
    .idle_i     (idle),
    .x_i        (active_q),
    .out_o      (out),
    .overload_o (overload)
  );

endmodule

// File: tb/tb_sdm2_echip65.sv
// Directed bench for sdm2_echip65 (default parameters, SDM2_DITHER_EN undefined).
// Cycle numbers count rising edges since reset release; enable rises before edge 4.
module tb_sdm2_echip65;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready, out, divided_clk, underrun, overload;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ones_acc = 0;
  int urun_acc = 0;

  always #5 clk = ~clk;

  sdm2_echip65 dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out         (out),
    .divided_clk (divided_clk),
    .underrun    (underrun),
    .overload    (overload)
  );

  // Running totals sampled mid-cycle; windows are differences of two snapshots.
  always @(negedge clk) begin
    ones_acc += int'(out);
    urun_acc += int'(underrun);
  end

  task automatic check(input string tag, input int got, input int exp, input int tol = 0);
    checks++;
    if (got < exp - tol || got > exp + tol) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (+/-%0d)", tag, got, exp, tol);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic restart();
    reset_n  = 1'b0;
    enable   = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    tick();
    tick();
    reset_n = 1'b1;
    cyc     = 0;
  endtask

  task automatic start(input logic [15:0] x);
    run_to(3);
    enable   = 1'b1;
    in_valid = 1'b1;
    in_data  = x;
  endtask

  int s0, s1, s2, s3, u0, o1;

  initial begin
    // Zero input: reset values, PRIME toggling, divided clock, handshake, density.
    restart();
    check("rst_in_ready", in_ready, 1);
    check("rst_out", out, 0);
    check("rst_divclk", divided_clk, 0);
    check("rst_underrun", underrun, 0);
    check("rst_overload", overload, 0);
    u0 = urun_acc;
    run_to(2);  check("idle_out_c2", out, 0);
    run_to(3);  check("idle_out_c3", out, 1);
    start(16'h0000);
    run_to(4);   check("prime_in_ready", in_ready, 0);
    check("prime_divclk_c4", divided_clk, 0);
    run_to(132); check("divclk_c132", divided_clk, 0);
    run_to(133); check("divclk_c133", divided_clk, 1);
    run_to(259); check("prime_out_c259", out, 1);
    run_to(260); check("divclk_c260", divided_clk, 1);
    check("boundary_in_ready", in_ready, 1);
    check("prime_out_c260", out, 0);
    run_to(261); check("divclk_c261", divided_clk, 0);
    check("refill_in_ready", in_ready, 0);
    run_to(773); s0 = ones_acc;
    run_to(1029);
    check("ones_zero", ones_acc - s0, 128, 2);
    check("overload_zero", overload, 0);
    check("no_underrun", urun_acc - u0, 0);

    // Half positive full scale.
    restart();
    start(16'h4000);
    run_to(773); s0 = ones_acc;
    run_to(1029);
    check("ones_half", ones_acc - s0, 192, 2);

    // Withheld sample for one period: single underrun pulse, density unchanged.
    restart();
    u0 = urun_acc;
    start(16'h0000);
    run_to(260); in_valid = 1'b0;
    run_to(515); check("urun_c515", underrun, 0);
    run_to(516); check("urun_c516", underrun, 1);
    in_valid = 1'b1;
    run_to(517); check("urun_c517", underrun, 0);
    run_to(773); s0 = ones_acc;
    run_to(1029);
    check("ones_after_urun", ones_acc - s0, 128, 2);
    check("urun_pulses", urun_acc - u0, 1);

    // Three samples in order; offer held off while holding register is full.
    restart();
    start(16'h0000);
    run_to(260); in_data = 16'h4000;
    check("ord_ready_c260", in_ready, 1);
    run_to(261); check("ord_ready_c261", in_ready, 0);
    in_data = 16'hC000;
    s0 = ones_acc;
    run_to(515); check("ord_ready_c515", in_ready, 0);
    run_to(516); check("ord_ready_c516", in_ready, 1);
    run_to(517); check("ord_ready_c517", in_ready, 0);
    in_valid = 1'b0;
    s1 = ones_acc;
    run_to(773); s2 = ones_acc;
    run_to(1028); check("ord_underrun", underrun, 1);
    run_to(1029); s3 = ones_acc;
    check("ord_ones_a", s1 - s0, 128, 4);
    check("ord_ones_b", s2 - s1, 192, 4);
    check("ord_ones_c", s3 - s2, 64, 4);

    // Near full scale drives the loop into saturation; IDLE clears the flag.
    restart();
    start(16'h7FFF);
    run_to(259);  check("ovl_prime", overload, 0);
    run_to(400);  check("ovl_c400", overload, 1);
    run_to(1300); check("ovl_c1300", overload, 1);
    run_to(2308); check("ovl_c2308", overload, 1);
    enable = 1'b0;
    run_to(2311); check("ovl_idle", overload, 0);
    o1 = int'(out);
    run_to(2312); check("idle_toggle", int'(out) ^ o1, 1);
    check("idle_divclk", divided_clk, 0);

    // Asynchronous reset in the middle of a period.
    restart();
    start(16'h7FFF);
    run_to(460);
    check("pre_divclk", divided_clk, 1);
    check("pre_in_ready", in_ready, 0);
    check("pre_overload", overload, 1);
    #2;
    reset_n  = 1'b0;
    enable   = 1'b0;
    in_valid = 1'b0;
    #1;
    check("arst_in_ready", in_ready, 1);
    check("arst_out", out, 0);
    check("arst_divclk", divided_clk, 0);
    check("arst_underrun", underrun, 0);
    check("arst_overload", overload, 0);
    tick();
    reset_n = 1'b1;
    cyc = 0;
    run_to(1);
    check("post_in_ready", in_ready, 1);
    check("post_out", out, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdm2_echip65.md
SDM2_ECHIP65 -- requirements
Module: sdm2_echip65

Interface
REQ-001 SHALL provide parameter DECIMATION_FACTOR, default 256: output bits per input sample, power of two.
REQ-002 SHALL provide parameter IN_WIDTH, default 16: signed two's-complement input sample width.
REQ-003 SHALL provide parameter ACC_WIDTH, default IN_WIDTH+4: integrator width.
REQ-004 SHALL have port clk  input  1  modulator clock.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port enable  input  1  run request.
REQ-007 SHALL have port in_data  input  IN_WIDTH  signed sample.
REQ-008 SHALL have port in_valid  input  1  sample offered.
REQ-009 SHALL have port in_ready  output  1  holding register empty.
REQ-010 SHALL have port out  output  1  sigma-delta bitstream, CIC-compatible (1 = +FS).
REQ-011 SHALL have port divided_clk  output  1  clk divided by DECIMATION_FACTOR, 50% duty.
REQ-012 SHALL have port underrun  output  1  one-cycle pulse, no sample at boundary.
REQ-013 SHALL have port overload  output  1  sticky integrator-saturation flag.

Function
REQ-014 SHALL use FSM states IDLE, PRIME, RUN; IDLE->PRIME on enable; PRIME->RUN at first sample boundary; any state->IDLE the cycle after enable falls.
REQ-015 SHALL run a free counter cnt (log2 D bits) in PRIME/RUN, held at 0 in IDLE; sample boundary is cycle with cnt==D-1; divided_clk is registered cnt MSB.
REQ-016 SHALL accept a sample on posedge clk with in_valid&&in_ready into a one-entry holding register; in_ready low while full.
REQ-017 SHALL at each boundary move holding register to active sample and free it; boundary and handshake in same cycle: active takes old holding content, new sample stays held.
REQ-018 SHALL at a boundary with empty holding register reuse the previous active sample and pulse underrun (RUN only; PRIME waits, no pulse).
REQ-019 SHALL per clk in RUN compute fb = out ? +2^(IN_WIDTH-1) : -2^(IN_WIDTH-1); int1 += x - fb; int2 += int1_new - fb; out <= (int2_new >= 0); x sign-extended to ACC_WIDTH.
REQ-020 SHALL saturate int1/int2 to ACC_WIDTH signed limits and set overload on any saturation; overload clears only on reset or IDLE entry.
REQ-021 SHALL in IDLE/PRIME clear integrators and toggle out every cycle (zero-valued 0101 pattern).

Reset
REQ-022 SHALL on reset_n low force: state IDLE, cnt 0, integrators 0, holding empty, in_ready 1, out 0, divided_clk 0, underrun 0, overload 0.
REQ-023 SHALL discard holding/active samples on reset mid-operation; first bit after release follows REQ-021.

Configuration
REQ-024 SHALL with SDM2_DITHER_EN defined add LFSR bit (15-bit LFSR x^15+x^14+1, seed 15'h1) as +/-1 LSB to quantizer input int2_new; LFSR advances in RUN only.
REQ-025 SHALL without SDM2_DITHER_EN contain no LFSR flops; quantizer input equals int2_new exactly.

Structure
REQ-026 SHALL place state enum, full-scale constant helper and LFSR polynomial in package sdm2_echip65_pkg.
REQ-027 SHALL isolate integrator loop, saturation and quantizer in sub-module sdm2_echip65_loop; top holds FSM, counter, handshake.

Verification
REQ-028 Constant in_data=0, always valid, D=256 -> ones per 256 RUN cycles 128+/-2, overload 0.
REQ-029 Constant in_data=16'h4000 -> ones per 256 cycles 192+/-2; via cic3 D=256 settled output 12582912+/-2^17.
REQ-030 in_valid withheld one period in RUN -> underrun single pulse at boundary, bitstream unchanged in density.
REQ-031 in_valid high on boundary cycle with holding full -> no sample lost, two consecutive periods use samples in order.
REQ-032 in_data=16'h7FFF for 2048 cycles -> overload set and stays set; enable low -> IDLE, overload 0, out toggles.
REQ-033 reset_n pulsed low mid-RUN -> all outputs at REQ-022 values asynchronously, in_ready 1 next cycle.
